// File: rtl/capture_pkg.sv
// Shared types and constants for the capture write scheduler.
// Latency: none (declarations only).
// Backpressure: not applicable.
package capture_pkg;

  localparam int NPORTS = 4;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 13;
  localparam int DEPTH  = 1 << ADDR_W;

  // CTRL register address and bit positions within writedata
  localparam int CTRL_ADDR  = 0;
  localparam int CTRL_START = 0;
  localparam int CTRL_STOP  = 1;
  localparam int CTRL_CLEAR = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FULL = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arbiter4.sv
// Four-way round-robin arbiter: first requester after 'last', wrapping modulo 4.
// Latency: purely combinational, zero cycles.
// Backpressure: at most one grant; non-granted requesters wait.
module rr_arbiter4 (
  input  logic [3:0] req,
  input  logic [1:0] last,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx
);

  logic [1:0] cand;

  // Scan from farthest to nearest candidate so the nearest requester after 'last' wins
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    cand    = '0;
    for (int i = 4; i >= 1; i--) begin
      cand = last + 2'(i);
      if (req[cand]) begin
        gnt     = 4'b0001 << cand;
        gnt_idx = cand;
      end
    end
  end

endmodule

// File: rtl/capture_sched.sv
// Round-robin scheduler sharing one capture RAM write port among four ports; runs the capture FSM and counters.
// Latency: accept-to-RAM write one cycle; sustains one write per cycle.
// Backpressure: req_ready is granted to one valid port per cycle in RUN only; zero in IDLE and FULL.
module capture_sched #(
  parameter int NPORTS = capture_pkg::NPORTS,
  parameter int DATA_W = capture_pkg::DATA_W,
  parameter int ADDR_W = capture_pkg::ADDR_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                chipselect,
  input  logic                write,
  input  logic [3:0]          address,
  input  logic [31:0]         writedata,
  input  logic [NPORTS-1:0]   req_valid,
  input  logic [DATA_W-1:0]   req_data [NPORTS],
  output logic [NPORTS-1:0]   req_ready,
  output logic                ram_wren,
  output logic [ADDR_W-1:0]   ram_wraddress,
  output logic [DATA_W-1:0]   ram_data,
  output logic [1:0]          ram_tag,
  output logic                running,
  output logic                full,
  output logic [ADDR_W:0]     word_count,
  output logic [31:0]         total_time
);

  import capture_pkg::state_t;
  import capture_pkg::IDLE;
  import capture_pkg::RUN;
  import capture_pkg::FULL;
  import capture_pkg::CTRL_ADDR;
  import capture_pkg::CTRL_START;
  import capture_pkg::CTRL_STOP;
  import capture_pkg::CTRL_CLEAR;

  // Capacity as a count value: the single set bit just above the address range
  localparam logic [ADDR_W:0] DEPTH_C = {1'b1, {ADDR_W{1'b0}}};

  state_t          state;
  logic [1:0]      last_grant;
  logic [3:0]      gnt;
  logic [1:0]      gnt_idx;
  logic            accept;
  logic            ctrl_wr;
  logic            do_clear;
  logic            do_stop;
  logic            do_start;
  logic [ADDR_W:0] pending_cnt;
  logic            unused_wd;

  // Only bits 0..2 of CTRL carry meaning
  assign unused_wd = ^writedata[31:3];

  // CTRL decode with clear > stop > start
  assign ctrl_wr  = chipselect && write && (address == 4'(CTRL_ADDR));
  assign do_clear = ctrl_wr && writedata[CTRL_CLEAR];
  assign do_stop  = ctrl_wr && writedata[CTRL_STOP] && !do_clear;
  assign do_start = ctrl_wr && writedata[CTRL_START] && !do_clear && !writedata[CTRL_STOP];

  // Words committed so far, counting the write still in flight on the RAM port;
  // word_count lags accepts by one cycle, so capacity decisions use this instead.
  assign pending_cnt = word_count + (ADDR_W+1)'(ram_wren);

  rr_arbiter4 u_arb (
    .req     (req_valid),
    .last    (last_grant),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // Grants are only visible while capturing
  assign req_ready = (state == RUN) ? gnt : '0;
  assign accept    = (state == RUN) && (|gnt);

  // Capture FSM with registered status outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      running <= 1'b0;
      full    <= 1'b0;
    end else if (do_clear) begin
      state   <= IDLE;
      running <= 1'b0;
      full    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (do_start) begin
            if (pending_cnt < DEPTH_C) begin
              state   <= RUN;
              running <= 1'b1;
            end else begin
              state <= FULL;
              full  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (do_stop) begin
            state   <= IDLE;
            running <= 1'b0;
          end else if (accept && (pending_cnt == DEPTH_C - 1'b1)) begin
            state   <= FULL;
            running <= 1'b0;
            full    <= 1'b1;
          end
        end
        FULL: begin
          state <= FULL;
        end
        default: begin
          state   <= IDLE;
          running <= 1'b0;
          full    <= 1'b0;
        end
      endcase
    end
  end

  // Register the accepted word toward the RAM; the write pulse lasts one cycle per accept
  always_ff @(posedge clk) begin
    if (reset) begin
      ram_wren <= 1'b0;
      ram_data <= '0;
      ram_tag  <= '0;
    end else begin
      ram_wren <= accept;
      if (accept) begin
        ram_data <= req_data[gnt_idx];
        ram_tag  <= gnt_idx;
      end
    end
  end

  // Round-robin pointer: follows the last accepted port, parked on the highest port after clear
  always_ff @(posedge clk) begin
    if (reset || do_clear) begin
      last_grant <= 2'(NPORTS - 1);
    end else if (accept) begin
      last_grant <= gnt_idx;
    end
  end

  // Address and word count advance after the write they describe has been presented
  always_ff @(posedge clk) begin
    if (reset || do_clear) begin
      ram_wraddress <= '0;
      word_count    <= '0;
    end else if (ram_wren) begin
      ram_wraddress <= ram_wraddress + 1'b1;
      word_count    <= word_count + 1'b1;
    end
  end

  // Saturating run-time counter
  always_ff @(posedge clk) begin
    if (reset || do_clear) begin
      total_time <= '0;
    end else if ((state == RUN) && (total_time != 32'hFFFF_FFFF)) begin
      total_time <= total_time + 1'b1;
    end
  end

endmodule
